spi_pixel_rx: RTL and testbench

// - MCU-facing front end of the VGA path: a mode-0 SPI slave (no chip select) on sck/sdi/sdo.
// - Oversamples SPI with the 48 MHz HSOSC clk; frames arrive as 32-bit commands.
// - Decoded commands become write strobes on the framebuffer write port read by the VGA scan-out.
// - Also runs a hardware screen-fill sweep and returns one status byte on sdo per frame.

---
 rtl/fb_pkg.sv | 46 ++++
 rtl/spi_sync_edge.sv | 44 ++++
 rtl/spi_pixel_rx.sv | 224 ++++++++++++++++++++++
 tb/tb_spi_pixel_rx.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/fb_pkg.sv
// fb_pkg: shared framebuffer constants, types and helpers for the VGA
// write path.
//   H_PIX/V_PIX        framebuffer geometry in pixels
//   COLOR_W            pixel width {r[3:0],g[3:0],b[3:0]}
//   ADDR_W             framebuffer address width
//   pixel_t            one pixel
//   cmd_e              decoded SPI command
//   fill_state_e       screen-fill sweep states
package fb_pkg;

    localparam int H_PIX   = 160;
    localparam int V_PIX   = 120;
    localparam int COLOR_W = 12;
    localparam int ADDR_W  = 15;
    localparam int FB_SIZE = H_PIX * V_PIX;

    localparam logic [7:0]        X_LIM     = 8'(H_PIX);
    localparam logic [7:0]        Y_LIM     = 8'(V_PIX);
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(FB_SIZE - 1);

    typedef logic [COLOR_W-1:0] pixel_t;

    typedef enum logic [1:0] {CMD_NOP, CMD_WRITE, CMD_FILL} cmd_e;

    typedef enum logic [1:0] {IDLE, FILL, DRAIN} fill_state_e;

    // Any opcode other than WRITE/FILL is treated as a NOP.
    function automatic cmd_e decode_cmd(input logic [3:0] code);
        case (code)
            4'h1:    return CMD_WRITE;
            4'h2:    return CMD_FILL;
            default: return CMD_NOP;
        endcase
    endfunction

    // y*160 + x built from shifts: 160 = 128 + 32.
    function automatic logic [ADDR_W-1:0] xy_to_addr(input logic [7:0] x,
                                                     input logic [7:0] y);
        logic [ADDR_W-1:0] yw;
        logic [ADDR_W-1:0] xw;
        yw = ADDR_W'(y);
        xw = ADDR_W'(x);
        return (yw << 7) + (yw << 5) + xw;
    endfunction

endpackage

// File: rtl/spi_sync_edge.sv
// spi_sync_edge: brings the asynchronous SPI sck/sdi into the clk domain
// and produces single-cycle edge pulses for sck.
//   clk       system clock
//   reset     asynchronous active-low reset
//   sck, sdi  raw SPI inputs
//   sck_rise  one-cycle pulse on a synchronised rising sck edge
//   sck_fall  one-cycle pulse on a synchronised falling sck edge
//   sdi_sync  sdi through the same 2-flop depth as sck, so the bit seen
//             during sck_rise is the one the MCU held at that edge
module spi_sync_edge (
    input  logic clk,
    input  logic reset,
    input  logic sck,
    input  logic sdi,
    output logic sck_rise,
    output logic sck_fall,
    output logic sdi_sync
);

    logic sck_meta;
    logic sck_sync;
    logic sck_prev;
    logic sdi_meta;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sck_meta <= 1'b0;
            sck_sync <= 1'b0;
            sck_prev <= 1'b0;
            sdi_meta <= 1'b0;
            sdi_sync <= 1'b0;
        end else begin
            sck_meta <= sck;
            sck_sync <= sck_meta;
            sck_prev <= sck_sync;
            sdi_meta <= sdi;
            sdi_sync <= sdi_meta;
        end
    end

    assign sck_rise = sck_sync & ~sck_prev;
    assign sck_fall = ~sck_sync & sck_prev;

endmodule

// File: rtl/spi_pixel_rx.sv
// spi_pixel_rx: mode-0 SPI slave front end of the VGA path. Receives
// 32-bit command frames {cmd,x,y,rgb}, turns them into framebuffer write
// strobes, runs a hardware screen-fill sweep and returns a status byte on
// sdo at the start of each frame.
//   clk        48 MHz system clock
//   reset      asynchronous active-low reset
//   sck/sdi    SPI clock/data from the MCU (sck idles low, MSB first)
//   sdo        status byte {fill_busy, pending, err_count[5:0]}, MSB first
//   wr_en      one-cycle framebuffer write strobe
//   wr_addr    y*H_PIX + x
//   wr_data    pixel colour
//   fill_busy  high while fill writes are on the port
//   err_count  dropped-command counter, saturating at 255
module spi_pixel_rx
    import fb_pkg::*;
#(
    parameter int TIMEOUT_CYC = 4800
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              sck,
    input  logic              sdi,
    output logic              sdo,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output pixel_t            wr_data,
    output logic              fill_busy,
    output logic [7:0]        err_count
);

    localparam int IDLE_W = $clog2(TIMEOUT_CYC + 1);

    logic              sck_rise;
    logic              sck_fall;
    logic              sdi_sync;

    logic [30:0]       shift_reg;
    logic [4:0]        bit_cnt;
    logic [IDLE_W-1:0] idle_cnt;
    logic [31:0]       frame;
    logic              frame_vld;
    logic [7:0]        status_sh;

    fill_state_e       state,      state_nxt;
    logic [ADDR_W-1:0] fill_addr,  fill_addr_nxt;
    pixel_t            fill_color, fill_color_nxt;
    logic              pend_valid, pend_valid_nxt;
    logic [ADDR_W-1:0] pend_addr,  pend_addr_nxt;
    pixel_t            pend_data,  pend_data_nxt;
    logic [7:0]        err_nxt;

    cmd_e              cmd;
    logic              in_range;
    logic              err_inc;
    logic              pend_issue;
    logic              issue_en;
    logic [ADDR_W-1:0] issue_addr;
    pixel_t            issue_data;

    spi_sync_edge u_sync (
        .clk      (clk),
        .reset    (reset),
        .sck      (sck),
        .sdi      (sdi),
        .sck_rise (sck_rise),
        .sck_fall (sck_fall),
        .sdi_sync (sdi_sync)
    );

    // Framing: the 32nd rising edge hands the full word to decode and wraps
    // bit_cnt. A long sck silence drops any partial frame so the next frame
    // starts aligned; the idle counter saturates at the threshold.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            shift_reg <= '0;
            bit_cnt   <= '0;
            idle_cnt  <= '0;
            frame     <= '0;
            frame_vld <= 1'b0;
        end else begin
            frame_vld <= 1'b0;
            if (sck_rise) begin
                shift_reg <= {shift_reg[29:0], sdi_sync};
                bit_cnt   <= bit_cnt + 5'd1;
                idle_cnt  <= '0;
                if (bit_cnt == 5'd31) begin
                    frame     <= {shift_reg, sdi_sync};
                    frame_vld <= 1'b1;
                end
            end else if (sck_fall) begin
                idle_cnt <= '0;
            end else if (idle_cnt == IDLE_W'(TIMEOUT_CYC)) begin
                bit_cnt <= '0;
            end else begin
                idle_cnt <= idle_cnt + IDLE_W'(1);
            end
        end
    end

    // Status keeps tracking live state while between frames, then shifts
    // one bit per falling edge once the frame is underway.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            status_sh <= '0;
        end else if (bit_cnt == 5'd0 && !sck_rise) begin
            status_sh <= {fill_busy, pend_valid, err_count[5:0]};
        end else if (sck_fall) begin
            status_sh <= {status_sh[6:0], 1'b0};
        end
    end

    assign sdo = status_sh[7];

    assign cmd      = decode_cmd(frame[31:28]);
    assign in_range = (frame[27:20] < X_LIM) && (frame[19:12] < Y_LIM);

    // Fill FSM and write-port arbitration. The sweep owns the port while in
    // FILL; otherwise a held pending write goes first. A WRITE that cannot
    // get the port waits in the single pending slot, which may be refilled
    // in the same cycle it drains.
    always_comb begin
        state_nxt      = state;
        fill_addr_nxt  = fill_addr;
        fill_color_nxt = fill_color;
        pend_valid_nxt = pend_valid;
        pend_addr_nxt  = pend_addr;
        pend_data_nxt  = pend_data;
        err_nxt        = err_count;
        err_inc        = 1'b0;
        pend_issue     = 1'b0;
        issue_en       = 1'b0;
        issue_addr     = '0;
        issue_data     = '0;

        unique case (state)
            FILL: begin
                issue_en   = 1'b1;
                issue_addr = fill_addr;
                issue_data = fill_color;
                if (fill_addr == LAST_ADDR) begin
                    state_nxt = DRAIN;
                end else begin
                    fill_addr_nxt = fill_addr + ADDR_W'(1);
                end
            end
            DRAIN: begin
                state_nxt  = IDLE;
                pend_issue = pend_valid;
            end
            default: begin
                pend_issue = pend_valid;
            end
        endcase

        if (pend_issue) begin
            issue_en       = 1'b1;
            issue_addr     = pend_addr;
            issue_data     = pend_data;
            pend_valid_nxt = 1'b0;
        end

        if (frame_vld) begin
            unique case (cmd)
                CMD_FILL: begin
                    state_nxt      = FILL;
                    fill_addr_nxt  = '0;
                    fill_color_nxt = frame[11:0];
                end
                CMD_WRITE: begin
                    if (!in_range) begin
                        err_inc = 1'b1;
                    end else if (!issue_en) begin
                        issue_en   = 1'b1;
                        issue_addr = xy_to_addr(frame[27:20], frame[19:12]);
                        issue_data = frame[11:0];
                    end else if (!pend_valid || pend_issue) begin
                        pend_valid_nxt = 1'b1;
                        pend_addr_nxt  = xy_to_addr(frame[27:20], frame[19:12]);
                        pend_data_nxt  = frame[11:0];
                    end else begin
                        err_inc = 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end

        if (err_inc && err_count != 8'hFF) begin
            err_nxt = err_count + 8'd1;
        end
    end

    // fill_busy is registered alongside the write port so it lines up
    // exactly with the sweep's wr_en cycles.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            fill_addr  <= '0;
            fill_color <= '0;
            pend_valid <= 1'b0;
            pend_addr  <= '0;
            pend_data  <= '0;
            err_count  <= '0;
            wr_en      <= 1'b0;
            wr_addr    <= '0;
            wr_data    <= '0;
            fill_busy  <= 1'b0;
        end else begin
            state      <= state_nxt;
            fill_addr  <= fill_addr_nxt;
            fill_color <= fill_color_nxt;
            pend_valid <= pend_valid_nxt;
            pend_addr  <= pend_addr_nxt;
            pend_data  <= pend_data_nxt;
            err_count  <= err_nxt;
            wr_en      <= issue_en;
            wr_addr    <= issue_addr;
            wr_data    <= issue_data;
            fill_busy  <= (state == FILL);
        end
    end

endmodule

// File: tb/tb_spi_pixel_rx.sv
// tb_spi_pixel_rx: directed scoreboard bench for spi_pixel_rx. Expected
// framebuffer writes are queued as each command is sent and popped by a
// monitor when wr_en fires.
module tb_spi_pixel_rx;

    typedef struct packed {
        logic [14:0] addr;
        logic [11:0] data;
        logic        busy;
        logic        contig;
    } exp_t;

    logic        clk;
    logic        reset;
    logic        sck;
    logic        sdi;
    logic        sdo;
    logic        wr_en;
    logic [14:0] wr_addr;
    logic [11:0] wr_data;
    logic        fill_busy;
    logic [7:0]  err_count;

    int   checks;
    int   errors;
    exp_t sb[$];
    exp_t mon_e;
    logic prev_wr;
    logic loose;
    int   loose_writes;
    int   zero_cnt;
    logic [14:0] last_addr;
    logic [11:0] last_data;

    logic [7:0] st;
    logic       found;

    spi_pixel_rx dut (
        .clk       (clk),
        .reset     (reset),
        .sck       (sck),
        .sdi       (sdi),
        .sdo       (sdo),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .fill_busy (fill_busy),
        .err_count (err_count)
    );

    always #10 clk = ~clk;

    task automatic check_output(input string tag, input logic [31:0] obs,
                                input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] mk_frame(input logic [3:0] c,
                                             input logic [7:0] x,
                                             input logic [7:0] y,
                                             input logic [11:0] rgb);
        return {c, x, y, rgb};
    endfunction

    function automatic exp_t mk_exp(input int a, input logic [11:0] d,
                                    input logic b, input logic c);
        exp_t e;
        e.addr   = 15'(a);
        e.data   = d;
        e.busy   = b;
        e.contig = c;
        return e;
    endfunction

    // Sends nbits MSB-first; sdo is sampled just before each of the first
    // eight rising edges.
    task automatic apply_stimulus(input logic [31:0] word, input int nbits,
                                  output logic [7:0] status);
        status = 8'h00;
        for (int i = 0; i < nbits; i++) begin
            sdi = word[31-i];
            repeat (6) @(negedge clk);
            if (i < 8) status = {status[6:0], sdo};
            sck = 1'b1;
            repeat (6) @(negedge clk);
            sck = 1'b0;
        end
        sdi = 1'b0;
        repeat (6) @(negedge clk);
    endtask

    task automatic wait_drain(input int budget, input string tag);
        for (int i = 0; i < budget && sb.size() != 0; i++) @(negedge clk);
        check_output(tag, sb.size(), 0);
        repeat (20) @(negedge clk);
    endtask

    task automatic wait_busy_low(input int budget, input string tag);
        for (int i = 0; i < budget && fill_busy !== 1'b0; i++) @(negedge clk);
        check_output(tag, fill_busy, 0);
    endtask

    // Write monitor: strict mode pops the scoreboard, loose mode only
    // records the traffic for later inspection.
    always @(negedge clk) begin
        if (reset === 1'b1 && wr_en === 1'b1) begin
            if (loose) begin
                loose_writes++;
                if (wr_addr == 15'd0) zero_cnt++;
                last_addr = wr_addr;
                last_data = wr_data;
            end else begin
                check_output("unexpected_write", (sb.size() > 0), 1);
                if (sb.size() > 0) begin
                    mon_e = sb.pop_front();
                    check_output("wr_addr", wr_addr, mon_e.addr);
                    check_output("wr_data", wr_data, mon_e.data);
                    check_output("wr_fill_busy", fill_busy, mon_e.busy);
                    if (mon_e.contig) check_output("wr_contig", prev_wr, 1);
                end
            end
        end
        prev_wr = wr_en;
    end

    initial begin
        clk = 1'b0; reset = 1'b0; sck = 1'b0; sdi = 1'b0;
        checks = 0; errors = 0; prev_wr = 1'b0; loose = 1'b0;
        loose_writes = 0; zero_cnt = 0; last_addr = '0; last_data = '0;
        found = 1'b0;

        repeat (5) @(negedge clk);
        check_output("rst_wr_en", wr_en, 0);
        check_output("rst_wr_addr", wr_addr, 0);
        check_output("rst_fill_busy", fill_busy, 0);
        check_output("rst_err_count", err_count, 0);
        check_output("rst_sdo", sdo, 0);
        reset = 1'b1;
        repeat (5) @(negedge clk);

        $display("[TB] single write");
        sb.push_back(mk_exp(325, 12'hF0A, 1'b0, 1'b0));
        apply_stimulus(mk_frame(4'h1, 8'd5, 8'd2, 12'hF0A), 32, st);
        check_output("status_fresh", st, 8'h00);
        wait_drain(200, "write_325_drain");

        $display("[TB] out-of-range writes");
        apply_stimulus(mk_frame(4'h1, 8'd160, 8'd0, 12'h111), 32, st);
        repeat (20) @(negedge clk);
        check_output("err_x_oob", err_count, 1);
        apply_stimulus(mk_frame(4'h0, 8'd0, 8'd0, 12'h000), 32, st);
        check_output("status_err1", st, 8'h01);
        apply_stimulus(mk_frame(4'h1, 8'd0, 8'd120, 12'h222), 32, st);
        repeat (20) @(negedge clk);
        check_output("err_y_oob", err_count, 2);
        sb.push_back(mk_exp(19199, 12'h5A5, 1'b0, 1'b0));
        apply_stimulus(mk_frame(4'h1, 8'd159, 8'd119, 12'h5A5), 32, st);
        wait_drain(200, "write_corner_drain");
        check_output("err_after_corner", err_count, 2);

        $display("[TB] fill with pending write");
        for (int a = 0; a < 19200; a++) sb.push_back(mk_exp(a, 12'h00F, 1'b1, a != 0));
        apply_stimulus(mk_frame(4'h2, 8'hAA, 8'hBB, 12'h00F), 32, st);
        check_output("status_pre_fill", st, 8'h02);
        sb.push_back(mk_exp(161, 12'h123, 1'b0, 1'b1));
        apply_stimulus(mk_frame(4'h1, 8'd1, 8'd1, 12'h123), 32, st);
        check_output("status_busy", st, 8'h82);
        apply_stimulus(mk_frame(4'h1, 8'd2, 8'd2, 12'h456), 32, st);
        check_output("status_busy_pend", st, 8'hC2);
        repeat (20) @(negedge clk);
        check_output("err_pend_full", err_count, 3);
        check_output("busy_mid_fill", fill_busy, 1);
        wait_drain(25000, "fill_drain");
        check_output("busy_after_fill", fill_busy, 0);

        $display("[TB] fill restart");
        loose = 1'b1; zero_cnt = 0;
        apply_stimulus(mk_frame(4'h2, 8'd0, 8'd0, 12'h00F), 32, st);
        repeat (100) @(negedge clk);
        apply_stimulus(mk_frame(4'h2, 8'd0, 8'd0, 12'h0F0), 32, st);
        check_output("status_restart", st, 8'h83);
        wait_busy_low(25000, "restart_busy_low");
        repeat (5) @(negedge clk);
        check_output("restart_zero_cnt", zero_cnt, 2);
        check_output("restart_last_addr", last_addr, 19199);
        check_output("restart_last_data", last_data, 12'h0F0);
        loose = 1'b0;

        $display("[TB] framing timeout");
        apply_stimulus(32'h1234_5678, 17, st);
        repeat (6000) @(negedge clk);
        sb.push_back(mk_exp(0, 12'hFFF, 1'b0, 1'b0));
        apply_stimulus(mk_frame(4'h1, 8'd0, 8'd0, 12'hFFF), 32, st);
        wait_drain(200, "timeout_write_drain");
        check_output("err_after_timeout", err_count, 3);

        $display("[TB] reset during fill");
        loose = 1'b1;
        apply_stimulus(mk_frame(4'h2, 8'd0, 8'd0, 12'hABC), 32, st);
        for (int i = 0; i < 25000 && !found; i++) begin
            @(negedge clk);
            if (wr_en === 1'b1 && wr_addr == 15'd1000) found = 1'b1;
        end
        check_output("reached_addr_1000", found, 1);
        reset = 1'b0;
        #1;
        check_output("rst_mid_wr_en", wr_en, 0);
        check_output("rst_mid_busy", fill_busy, 0);
        check_output("rst_mid_err", err_count, 0);
        repeat (5) @(negedge clk);
        reset = 1'b1;
        loose_writes = 0;
        repeat (200) @(negedge clk);
        check_output("no_write_after_rst", loose_writes, 0);
        check_output("busy_after_rst", fill_busy, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
